f1_xlate_mp: RTL and testbench
==============================

Name: f1_xlate_mp

Overview:
- Parametrised successor to the frontend F1 address-translation stage.
- Translates NUM_PORTS cache-line addresses per cycle (default 2: even/odd) through a fully associative TLB of TLB_ENTRIES entries, producing registered physical addresses.
- Misses are serviced by a sequential page-walk request/acknowledge FSM; upstream is back-pressured while a walk is in progress.
- Sits between the fetch-PC/line generator (F0) and the I-cache tag stage (F2).

Parameters:
- XLEN, 32, physical/virtual address width.
- CLC_WIDTH, 28, cache-line address width; line offset bits LOFF = XLEN-CLC_WIDTH.
- PAGE_BITS, 12, page offset width; VPN/PPN width VPNW = XLEN-PAGE_BITS.
- NUM_PORTS, 2, lookup channels per cycle; channel 0 has the highest priority.
- TLB_ENTRIES, 8, number of TLB entries; must be a power of 2 and at least 2.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- clc_in, in, NUM_PORTS*CLC_WIDTH, line addresses; channel i is slice i.
- clc_valid_in, in, NUM_PORTS, per-channel request valid.
- stall_in, in, 1, downstream stall; holds the output register.
- flush_in, in, 1, pipeline flush; kills the output register and any pending replay.
- tlb_inval_in, in, 1, invalidate all TLB entries and the fault register.
- busy_out, out, 1, walk in progress; upstream must hold clc_in/clc_valid_in.
- paddr_out, out, NUM_PORTS*XLEN, translated address: {PPN, clc[PAGE_BITS-LOFF-1:0], LOFF'b0}.
- paddr_valid_out, out, NUM_PORTS, per-channel output valid.
- pcd_out, out, NUM_PORTS, page-cache-disable bit (MMIO).
- hit_out, out, 1, all valid channels hit this cycle.
- exception_out, out, NUM_PORTS, page fault on that channel.
- walk_req, out, 1, walk request.
- walk_vpn, out, VPNW, VPN to walk; stable while walk_req=1.
- walk_ack, in, 1, walk complete (single-cycle pulse).
- walk_ppn, in, VPNW, returned PPN.
- walk_pcd, in, 1, returned PCD bit.
- walk_fault, in, 1, walk faulted.

Behaviour:
- Reset (rst=0, async): all TLB valid bits 0; fault register invalid; replacement pointer 0; FSM IDLE; all outputs 0.
- Lookup is combinational on clc_in. Channel VPN = clc[CLC_WIDTH-1 : PAGE_BITS-LOFF]. Results are registered, so output latency is 1 cycle.
- Channel i hits if clc_valid_in[i] and a valid entry's VPN matches. Channel i faults if its VPN matches a valid fault register.
- Output register, when stall_in=0 and FSM IDLE with no miss:
  - paddr_valid_out[i] = clc_valid_in[i].
  - paddr_out and pcd_out come from the matching entry.
  - exception_out[i] = fault match; paddr_out for that channel is 0.
  - hit_out = 1.
- stall_in=1: output register holds its value. The FSM still progresses.
- Miss (any valid channel not hit and not faulted):
  - Output valids are 0 and hit_out=0 that cycle.
  - FSM goes IDLE->WALK. The VPN of the lowest-index missing channel is latched into walk_vpn.
- WALK:
  - walk_req=1 and busy_out=1 until walk_ack.
  - On ack with walk_fault=0: write {vpn, ppn, pcd} into the victim entry -> REPLAY.
  - On ack with walk_fault=1: load the fault register with the VPN; no TLB write -> REPLAY.
- REPLAY: one cycle, busy_out=1, then IDLE. The held inputs are looked up again the next cycle. A second distinct missing VPN starts a new walk, so walks are sequential and in channel order.
- Same VPN on several missing channels: exactly one walk.
- Victim selection: the lowest-index invalid entry if any exists. Otherwise the round-robin pointer, which increments (mod TLB_ENTRIES) on each replacement-by-pointer.
- flush_in or tlb_inval_in during WALK: walk_req stays high until walk_ack (no abandoned handshake). The returned result is discarded (no TLB write, no fault load). The FSM then goes to IDLE, not REPLAY.
- flush_in in IDLE: output valids clear next cycle.
- tlb_inval_in: clears all valid bits and the fault register next cycle; it has priority over a same-cycle refill.
- flush_in and a miss in the same cycle: no walk is started.

Decomposition:
- Shared package f1_pkg:
  - FSM state enum {IDLE, WALK, REPLAY}.
  - tlb_entry_t {valid, vpn, ppn, pcd}.
  - Derived width constants LOFF and VPNW.
- One sub-module, f1_tlb_cam: parametrised entry array with NUM_PORTS match ports, one write port, victim/round-robin logic, and invalidate-all.

Test Plan:
- Reset then idle: with rst=0, all outputs are 0. After release, no walk_req without valid input.
- Miss then hit:
  - ch0 clc=0x0012345, ch1 invalid -> walk_req with walk_vpn=0x00123.
  - ack with ppn=0x0ABCD, pcd=0 -> the replay cycle after that gives paddr_out[0]=0x0ABCD450 with valid=1 and hit_out=1.
- Two channels:
  - Same page (clc 0x0012345 / 0x0012346) -> exactly one walk; both then hit.
  - Different pages (0x0012345 / 0x0045600) -> walk 0x00123, then walk 0x00456, in that order.
- Fault: walk_fault=1 for VPN 0x00777 -> exception_out[0]=1 and paddr_out[0]=0 after replay. tlb_inval_in clears it, so the next lookup re-walks.
- Flush mid-walk: flush_in while walk_req=1 -> walk_req held until walk_ack. The TLB is unchanged, so the same VPN misses again afterwards.
- Replacement: fill 8 distinct VPNs, then a 9th -> it evicts entry 0. A 10th evicts entry 1. Re-accessing VPN #1 misses; pcd_out follows walk_pcd=1 for an MMIO page.

Source files
------------

// File: rtl/f1_pkg.sv
// Shared types and default widths for the F1 multi-port address-translation stage.
//   - xlate_state_e : walk FSM states
//   - tlb_entry_t   : one TLB entry at the default widths
//   - LOFF / VPNW   : line-offset and page-number widths at the default widths
package f1_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned PAGE_BITS_DEF = 12;
  localparam int unsigned LOFF          = 4;
  localparam int unsigned VPNW          = XLEN_DEF - PAGE_BITS_DEF;

  typedef enum logic [1:0] {
    StIdle,
    StWalk,
    StReplay
  } xlate_state_e;

  typedef struct packed {
    logic            valid;
    logic [VPNW-1:0] vpn;
    logic [VPNW-1:0] ppn;
    logic            pcd;
  } tlb_entry_t;

endpackage

// File: rtl/f1_xlate_mp_if.sv
// Bundle of the F1 translation stage's upstream, downstream and page-walk signals.
//   slave  : seen from the translation stage (inputs: lookup request, control, walk response)
//   master : seen from the surrounding pipeline / walker
interface f1_xlate_mp_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CLC_WIDTH = 28,
  parameter int unsigned PAGE_BITS = 12,
  parameter int unsigned NUM_PORTS = 2
);
  localparam int unsigned VPNW = XLEN - PAGE_BITS;

  logic [NUM_PORTS*CLC_WIDTH-1:0] clc_in;
  logic [NUM_PORTS-1:0]           clc_valid_in;
  logic                           stall_in;
  logic                           flush_in;
  logic                           tlb_inval_in;
  logic                           busy_out;
  logic [NUM_PORTS*XLEN-1:0]      paddr_out;
  logic [NUM_PORTS-1:0]           paddr_valid_out;
  logic [NUM_PORTS-1:0]           pcd_out;
  logic                           hit_out;
  logic [NUM_PORTS-1:0]           exception_out;
  logic                           walk_req;
  logic [VPNW-1:0]                walk_vpn;
  logic                           walk_ack;
  logic [VPNW-1:0]                walk_ppn;
  logic                           walk_pcd;
  logic                           walk_fault;

  modport slave (
    input  clc_in, clc_valid_in, stall_in, flush_in, tlb_inval_in,
    input  walk_ack, walk_ppn, walk_pcd, walk_fault,
    output busy_out, paddr_out, paddr_valid_out, pcd_out, hit_out, exception_out,
    output walk_req, walk_vpn
  );

  modport master (
    output clc_in, clc_valid_in, stall_in, flush_in, tlb_inval_in,
    output walk_ack, walk_ppn, walk_pcd, walk_fault,
    input  busy_out, paddr_out, paddr_valid_out, pcd_out, hit_out, exception_out,
    input  walk_req, walk_vpn
  );

endinterface

// File: rtl/f1_tlb_cam.sv
// Fully associative TLB entry array.
//   lookup_vpn_i/_hit_o/_ppn_o/_pcd_o : NUM_PORTS combinational match ports
//   wr_en_i, wr_vpn_i/_ppn_i/_pcd_i   : refill port, written into the victim entry
//   inval_i                           : clear all valid bits (wins over a same-cycle refill)
// Victim is the lowest-index invalid entry, else the round-robin pointer.
module f1_tlb_cam
  import f1_pkg::*;
#(
  parameter int unsigned VpnW        = VPNW,
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned TLB_ENTRIES = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [VpnW-1:0]      lookup_vpn_i [NUM_PORTS],
  output logic [NUM_PORTS-1:0] lookup_hit_o,
  output logic [VpnW-1:0]      lookup_ppn_o [NUM_PORTS],
  output logic [NUM_PORTS-1:0] lookup_pcd_o,
  input  logic                 wr_en_i,
  input  logic [VpnW-1:0]      wr_vpn_i,
  input  logic [VpnW-1:0]      wr_ppn_i,
  input  logic                 wr_pcd_i,
  input  logic                 inval_i
);
  localparam int unsigned IdxW = $clog2(TLB_ENTRIES);

  typedef struct packed {
    logic            valid;
    logic [VpnW-1:0] vpn;
    logic [VpnW-1:0] ppn;
    logic            pcd;
  } entry_t;

  entry_t [TLB_ENTRIES-1:0] entry_q, entry_d;
  logic   [IdxW-1:0]        rr_q, rr_d;
  logic   [IdxW-1:0]        victim;
  logic                     any_free;

  // Scan downwards so the last assignment is the lowest free index.
  always_comb begin
    any_free = 1'b0;
    victim   = rr_q;
    for (int e = TLB_ENTRIES - 1; e >= 0; e--) begin
      if (!entry_q[e].valid) begin
        any_free = 1'b1;
        victim   = IdxW'(e);
      end
    end
  end

  // At most one entry matches, so OR-ing the masked fields selects it.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      lookup_hit_o[p] = 1'b0;
      lookup_ppn_o[p] = '0;
      lookup_pcd_o[p] = 1'b0;
      for (int e = 0; e < TLB_ENTRIES; e++) begin
        if (entry_q[e].valid && entry_q[e].vpn == lookup_vpn_i[p]) begin
          lookup_hit_o[p] = 1'b1;
          lookup_ppn_o[p] = lookup_ppn_o[p] | entry_q[e].ppn;
          lookup_pcd_o[p] = lookup_pcd_o[p] | entry_q[e].pcd;
        end
      end
    end
  end

  always_comb begin
    entry_d = entry_q;
    rr_d    = rr_q;
    if (inval_i) begin
      for (int e = 0; e < TLB_ENTRIES; e++) begin
        entry_d[e].valid = 1'b0;
      end
    end else if (wr_en_i) begin
      entry_d[victim] = '{valid: 1'b1, vpn: wr_vpn_i, ppn: wr_ppn_i, pcd: wr_pcd_i};
      if (!any_free) begin
        rr_d = rr_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
      rr_q    <= '0;
    end else begin
      entry_q <= entry_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: rtl/f1_xlate_mp.sv
// F1 address translation: NUM_PORTS cache-line addresses per cycle through a shared TLB,
// registered physical address out one cycle later. Misses run a sequential page walk.
//   clk, rst (async, active low)
//   xif_io.clc_in/clc_valid_in       : lookup requests, held by upstream while busy_out
//   xif_io.stall/flush/tlb_inval_in  : pipeline control
//   xif_io.paddr/pcd/exception/hit   : registered results
//   xif_io.walk_req/vpn, walk_ack... : page-walk handshake
module f1_xlate_mp
  import f1_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned CLC_WIDTH   = XLEN_DEF - LOFF,
  parameter int unsigned PAGE_BITS   = PAGE_BITS_DEF,
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned TLB_ENTRIES = 8
) (
  input logic          clk,
  input logic          rst,
  f1_xlate_mp_if.slave xif_io
);
  localparam int unsigned LoffW = XLEN - CLC_WIDTH;
  localparam int unsigned VpnW  = XLEN - PAGE_BITS;
  localparam int unsigned LineW = PAGE_BITS - LoffW;  // line-index bits inside a page

  xlate_state_e            state_q, state_d;
  logic [VpnW-1:0]         walk_vpn_q, walk_vpn_d;
  logic                    abort_q, abort_d;
  logic                    fault_valid_q, fault_valid_d;
  logic [VpnW-1:0]         fault_vpn_q, fault_vpn_d;
  logic                    tlb_wr, fault_load;

  logic [NUM_PORTS-1:0]      pv_q, pv_d, pcd_q, pcd_d, exc_q, exc_d;
  logic [NUM_PORTS*XLEN-1:0] paddr_q, paddr_d;
  logic                      hit_q, hit_d;

  logic [CLC_WIDTH-1:0] clc      [NUM_PORTS];
  logic [VpnW-1:0]      vpn      [NUM_PORTS];
  logic [VpnW-1:0]      cam_ppn  [NUM_PORTS];
  logic [NUM_PORTS-1:0] cam_hit, cam_pcd, fault_hit, miss;
  logic [VpnW-1:0]      miss_vpn;
  logic                 any_miss;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign clc[g]       = xif_io.clc_in[g*CLC_WIDTH +: CLC_WIDTH];
    assign vpn[g]       = clc[g][CLC_WIDTH-1:LineW];
    assign fault_hit[g] = fault_valid_q && (vpn[g] == fault_vpn_q);
    assign miss[g]      = xif_io.clc_valid_in[g] && !cam_hit[g] && !fault_hit[g];
  end

  assign any_miss = |miss;

  // Lowest-index missing channel is walked first.
  always_comb begin
    miss_vpn = vpn[0];
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (miss[p]) miss_vpn = vpn[p];
    end
  end

  f1_tlb_cam #(
    .VpnW        (VpnW),
    .NUM_PORTS   (NUM_PORTS),
    .TLB_ENTRIES (TLB_ENTRIES)
  ) u_cam (
    .clk_i        (clk),
    .rst_ni       (rst),
    .lookup_vpn_i (vpn),
    .lookup_hit_o (cam_hit),
    .lookup_ppn_o (cam_ppn),
    .lookup_pcd_o (cam_pcd),
    .wr_en_i      (tlb_wr),
    .wr_vpn_i     (walk_vpn_q),
    .wr_ppn_i     (xif_io.walk_ppn),
    .wr_pcd_i     (xif_io.walk_pcd),
    .inval_i      (xif_io.tlb_inval_in)
  );

  // Walk FSM. A flush/invalidate during a walk still waits for the ack so the walker never
  // sees an abandoned request; abort_q remembers to drop the result.
  always_comb begin
    state_d    = state_q;
    walk_vpn_d = walk_vpn_q;
    abort_d    = abort_q;
    tlb_wr     = 1'b0;
    fault_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_miss && !xif_io.flush_in) begin
          state_d    = StWalk;
          walk_vpn_d = miss_vpn;
          abort_d    = 1'b0;
        end
      end
      StWalk: begin
        if (xif_io.flush_in || xif_io.tlb_inval_in) abort_d = 1'b1;
        if (xif_io.walk_ack) begin
          abort_d = 1'b0;
          if (abort_q || xif_io.flush_in || xif_io.tlb_inval_in) begin
            state_d = StIdle;
          end else begin
            tlb_wr     = !xif_io.walk_fault;
            fault_load = xif_io.walk_fault;
            state_d    = StReplay;
          end
        end
      end
      StReplay: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_vpn_d   = fault_vpn_q;
    if (xif_io.tlb_inval_in) begin
      fault_valid_d = 1'b0;
    end else if (fault_load) begin
      fault_valid_d = 1'b1;
      fault_vpn_d   = walk_vpn_q;
    end
  end

  // Output register: flush kills, stall holds, otherwise results only when idle with no miss.
  always_comb begin
    pv_d    = pv_q;
    pcd_d   = pcd_q;
    exc_d   = exc_q;
    paddr_d = paddr_q;
    hit_d   = hit_q;
    if (xif_io.flush_in || !xif_io.stall_in) begin
      pv_d    = '0;
      pcd_d   = '0;
      exc_d   = '0;
      paddr_d = '0;
      hit_d   = 1'b0;
      if (!xif_io.flush_in && state_q == StIdle && !any_miss) begin
        hit_d = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
          pv_d[p]  = xif_io.clc_valid_in[p];
          exc_d[p] = xif_io.clc_valid_in[p] && fault_hit[p];
          if (xif_io.clc_valid_in[p] && cam_hit[p] && !fault_hit[p]) begin
            paddr_d[p*XLEN +: XLEN] = {cam_ppn[p], clc[p][LineW-1:0], {LoffW{1'b0}}};
            pcd_d[p]                = cam_pcd[p];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      walk_vpn_q    <= '0;
      abort_q       <= 1'b0;
      fault_valid_q <= 1'b0;
      fault_vpn_q   <= '0;
      pv_q          <= '0;
      pcd_q         <= '0;
      exc_q         <= '0;
      paddr_q       <= '0;
      hit_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      walk_vpn_q    <= walk_vpn_d;
      abort_q       <= abort_d;
      fault_valid_q <= fault_valid_d;
      fault_vpn_q   <= fault_vpn_d;
      pv_q          <= pv_d;
      pcd_q         <= pcd_d;
      exc_q         <= exc_d;
      paddr_q       <= paddr_d;
      hit_q         <= hit_d;
    end
  end

  assign xif_io.busy_out        = (state_q != StIdle);
  assign xif_io.walk_req        = (state_q == StWalk);
  assign xif_io.walk_vpn        = walk_vpn_q;
  assign xif_io.paddr_out       = paddr_q;
  assign xif_io.paddr_valid_out = pv_q;
  assign xif_io.pcd_out         = pcd_q;
  assign xif_io.exception_out   = exc_q;
  assign xif_io.hit_out         = hit_q;

endmodule

// File: tb/tb_f1_xlate_mp.sv
// Directed bench for f1_xlate_mp: inputs change 1 time unit after a rising edge and outputs
// are sampled at that same point, i.e. well away from the edge.
module tb_f1_xlate_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  f1_xlate_mp_if #(.XLEN(32), .CLC_WIDTH(28), .PAGE_BITS(12), .NUM_PORTS(2)) xif ();

  f1_xlate_mp #(
    .XLEN        (32),
    .CLC_WIDTH   (28),
    .PAGE_BITS   (12),
    .NUM_PORTS   (2),
    .TLB_ENTRIES (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .xif_io (xif)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (xif.walk_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
  endtask

  // One-cycle ack pulse; returns with the ack already dropped.
  task automatic ack(input logic [19:0] ppn, input logic pcd, input logic fault);
    xif.walk_ack   = 1'b1;
    xif.walk_ppn   = ppn;
    xif.walk_pcd   = pcd;
    xif.walk_fault = fault;
    step();
    xif.walk_ack   = 1'b0;
    xif.walk_fault = 1'b0;
    xif.walk_pcd   = 1'b0;
  endtask

  task automatic inval_pulse();
    xif.clc_valid_in = 2'b00;
    xif.tlb_inval_in = 1'b1;
    step();
    xif.tlb_inval_in = 1'b0;
    step();
  endtask

  task automatic test_reset();
    xif.clc_in       = {28'h0012345, 28'h0012345};
    xif.clc_valid_in = 2'b11;
    cycles(3);
    vectors++;
    if (xif.walk_req !== 1'b0 || xif.busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_fsm: walk_req=%b busy=%b expected 0 0", xif.walk_req, xif.busy_out);
    end
    vectors++;
    if (xif.paddr_valid_out !== 2'b00 || xif.paddr_out !== 64'h0 || xif.hit_out !== 1'b0 ||
        xif.pcd_out !== 2'b00 || xif.exception_out !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_out: pv=%b paddr=%h hit=%b pcd=%b exc=%b expected all 0",
               xif.paddr_valid_out, xif.paddr_out, xif.hit_out, xif.pcd_out, xif.exception_out);
    end
    xif.clc_valid_in = 2'b00;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (xif.walk_req !== 1'b0 || xif.busy_out !== 1'b0 || xif.paddr_valid_out !== 2'b00) begin
        miscompares++;
        $display("FAIL idle_no_req: walk_req=%b busy=%b pv=%b expected 0 0 00",
                 xif.walk_req, xif.busy_out, xif.paddr_valid_out);
      end
    end
  endtask

  task automatic test_miss_hit();
    bit seen;
    xif.clc_in       = {28'h0, 28'h0012345};
    xif.clc_valid_in = 2'b01;
    wait_req(seen);
    vectors++;
    if (!seen || xif.walk_vpn !== 20'h00123) begin
      miscompares++;
      $display("FAIL miss_walk_vpn: seen=%b vpn=%h expected 1 00123", seen, xif.walk_vpn);
    end
    vectors++;
    if (xif.busy_out !== 1'b1 || xif.paddr_valid_out !== 2'b00 || xif.hit_out !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_outputs: busy=%b pv=%b hit=%b expected 1 00 0",
               xif.busy_out, xif.paddr_valid_out, xif.hit_out);
    end
    ack(20'h0ABCD, 1'b0, 1'b0);
    vectors++;
    if (xif.busy_out !== 1'b1 || xif.walk_req !== 1'b0) begin
      miscompares++;
      $display("FAIL replay_busy: busy=%b walk_req=%b expected 1 0", xif.busy_out, xif.walk_req);
    end
    cycles(2);
    vectors++;
    if (xif.paddr_out[31:0] !== 32'h0ABCD450 || xif.paddr_valid_out !== 2'b01 ||
        xif.hit_out !== 1'b1 || xif.pcd_out !== 2'b00 || xif.exception_out !== 2'b00) begin
      miscompares++;
      $display("FAIL hit_paddr: paddr=%h pv=%b hit=%b pcd=%b exc=%b expected 0abcd450 01 1 00 00",
               xif.paddr_out[31:0], xif.paddr_valid_out, xif.hit_out, xif.pcd_out,
               xif.exception_out);
    end
    vectors++;
    if (xif.paddr_out[63:32] !== 32'h0 || xif.walk_req !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_ch1_idle: paddr1=%h walk_req=%b expected 0 0",
               xif.paddr_out[63:32], xif.walk_req);
    end
  endtask

  task automatic test_two_channels();
    bit seen;
    inval_pulse();
    xif.clc_in       = {28'h0012346, 28'h0012345};
    xif.clc_valid_in = 2'b11;
    wait_req(seen);
    vectors++;
    if (!seen || xif.walk_vpn !== 20'h00123) begin
      miscompares++;
      $display("FAIL same_page_vpn: seen=%b vpn=%h expected 1 00123", seen, xif.walk_vpn);
    end
    ack(20'h11111, 1'b0, 1'b0);
    cycles(2);
    vectors++;
    if (xif.walk_req !== 1'b0 || xif.busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL same_page_one_walk: walk_req=%b busy=%b expected 0 0",
               xif.walk_req, xif.busy_out);
    end
    vectors++;
    if (xif.paddr_out !== 64'h11111460_11111450 || xif.paddr_valid_out !== 2'b11 ||
        xif.hit_out !== 1'b1) begin
      miscompares++;
      $display("FAIL same_page_hit: paddr=%h pv=%b hit=%b expected 1111146011111450 11 1",
               xif.paddr_out, xif.paddr_valid_out, xif.hit_out);
    end

    inval_pulse();
    xif.clc_in       = {28'h0045600, 28'h0012345};
    xif.clc_valid_in = 2'b11;
    wait_req(seen);
    vectors++;
    if (!seen || xif.walk_vpn !== 20'h00123) begin
      miscompares++;
      $display("FAIL two_page_first: seen=%b vpn=%h expected 1 00123", seen, xif.walk_vpn);
    end
    ack(20'h22222, 1'b0, 1'b0);
    wait_req(seen);
    vectors++;
    if (!seen || xif.walk_vpn !== 20'h00456) begin
      miscompares++;
      $display("FAIL two_page_second: seen=%b vpn=%h expected 1 00456", seen, xif.walk_vpn);
    end
    ack(20'h33333, 1'b0, 1'b0);
    cycles(2);
    vectors++;
    if (xif.paddr_out !== 64'h33333000_22222450 || xif.paddr_valid_out !== 2'b11 ||
        xif.hit_out !== 1'b1) begin
      miscompares++;
      $display("FAIL two_page_hit: paddr=%h pv=%b hit=%b expected 3333300022222450 11 1",
               xif.paddr_out, xif.paddr_valid_out, xif.hit_out);
    end
  endtask

  task automatic test_fault();
    bit seen;
    inval_pulse();
    xif.clc_in       = {28'h0, 28'h0077700};
    xif.clc_valid_in = 2'b01;
    wait_req(seen);
    vectors++;
    if (!seen || xif.walk_vpn !== 20'h00777) begin
      miscompares++;
      $display("FAIL fault_vpn: seen=%b vpn=%h expected 1 00777", seen, xif.walk_vpn);
    end
    ack(20'h12345, 1'b0, 1'b1);
    cycles(2);
    vectors++;
    if (xif.exception_out !== 2'b01 || xif.paddr_out[31:0] !== 32'h0 ||
        xif.paddr_valid_out !== 2'b01 || xif.walk_req !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_exc: exc=%b paddr=%h pv=%b walk_req=%b expected 01 0 01 0",
               xif.exception_out, xif.paddr_out[31:0], xif.paddr_valid_out, xif.walk_req);
    end
    xif.tlb_inval_in = 1'b1;
    step();
    xif.tlb_inval_in = 1'b0;
    wait_req(seen);
    vectors++;
    if (!seen || xif.walk_vpn !== 20'h00777) begin
      miscompares++;
      $display("FAIL fault_rewalk: seen=%b vpn=%h expected 1 00777", seen, xif.walk_vpn);
    end
    ack(20'h44444, 1'b0, 1'b0);
    cycles(2);
    vectors++;
    if (xif.exception_out !== 2'b00 || xif.paddr_out[31:0] !== 32'h44444000) begin
      miscompares++;
      $display("FAIL fault_cleared: exc=%b paddr=%h expected 00 44444000",
               xif.exception_out, xif.paddr_out[31:0]);
    end
  endtask

  task automatic test_flush();
    bit seen;
    inval_pulse();
    xif.clc_in       = {28'h0, 28'h0055500};
    xif.clc_valid_in = 2'b01;
    wait_req(seen);
    xif.flush_in = 1'b1;
    step();
    xif.flush_in = 1'b0;
    step();
    vectors++;
    if (!seen || xif.walk_req !== 1'b1 || xif.walk_vpn !== 20'h00555) begin
      miscompares++;
      $display("FAIL flush_req_held: seen=%b walk_req=%b vpn=%h expected 1 1 00555",
               seen, xif.walk_req, xif.walk_vpn);
    end
    ack(20'h55555, 1'b0, 1'b0);
    vectors++;
    if (xif.busy_out !== 1'b0 || xif.walk_req !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_to_idle: busy=%b walk_req=%b expected 0 0", xif.busy_out, xif.walk_req);
    end
    step();
    vectors++;
    if (xif.walk_req !== 1'b1 || xif.walk_vpn !== 20'h00555) begin
      miscompares++;
      $display("FAIL flush_tlb_unchanged: walk_req=%b vpn=%h expected 1 00555",
               xif.walk_req, xif.walk_vpn);
    end
    ack(20'h55555, 1'b0, 1'b0);
    cycles(2);
    vectors++;
    if (xif.paddr_out[31:0] !== 32'h55555000 || xif.paddr_valid_out !== 2'b01) begin
      miscompares++;
      $display("FAIL flush_rewalk_hit: paddr=%h pv=%b expected 55555000 01",
               xif.paddr_out[31:0], xif.paddr_valid_out);
    end
    xif.flush_in = 1'b1;
    step();
    xif.flush_in = 1'b0;
    vectors++;
    if (xif.paddr_valid_out !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_idle_kill: pv=%b expected 00", xif.paddr_valid_out);
    end
    xif.clc_in       = {28'h0, 28'h0066600};
    xif.flush_in     = 1'b1;
    step();
    xif.flush_in = 1'b0;
    vectors++;
    if (xif.walk_req !== 1'b0 || xif.busy_out !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_miss_no_walk: walk_req=%b busy=%b expected 0 0",
               xif.walk_req, xif.busy_out);
    end
    wait_req(seen);
    vectors++;
    if (!seen || xif.walk_vpn !== 20'h00666) begin
      miscompares++;
      $display("FAIL flush_miss_later: seen=%b vpn=%h expected 1 00666", seen, xif.walk_vpn);
    end
    ack(20'h66666, 1'b0, 1'b0);
    cycles(2);
  endtask

  task automatic test_stall();
    xif.clc_in       = {28'h0, 28'h0066610};
    xif.clc_valid_in = 2'b01;
    step();
    vectors++;
    if (xif.paddr_out[31:0] !== 32'h66666100 || xif.paddr_valid_out !== 2'b01) begin
      miscompares++;
      $display("FAIL stall_pre: paddr=%h pv=%b expected 66666100 01",
               xif.paddr_out[31:0], xif.paddr_valid_out);
    end
    xif.stall_in     = 1'b1;
    xif.clc_valid_in = 2'b00;
    cycles(2);
    vectors++;
    if (xif.paddr_out[31:0] !== 32'h66666100 || xif.paddr_valid_out !== 2'b01) begin
      miscompares++;
      $display("FAIL stall_hold: paddr=%h pv=%b expected 66666100 01",
               xif.paddr_out[31:0], xif.paddr_valid_out);
    end
    xif.stall_in = 1'b0;
    step();
    vectors++;
    if (xif.paddr_valid_out !== 2'b00) begin
      miscompares++;
      $display("FAIL stall_release: pv=%b expected 00", xif.paddr_valid_out);
    end
  endtask

  task automatic test_replacement();
    bit          seen;
    logic [19:0] v;
    logic [19:0] p;
    inval_pulse();
    for (int k = 1; k <= 10; k++) begin
      v = 20'h00100 + 20'(k);
      p = 20'h0A000 + 20'(k);
      xif.clc_in       = {28'h0, v, 8'h00};
      xif.clc_valid_in = 2'b01;
      wait_req(seen);
      vectors++;
      if (!seen || xif.walk_vpn !== v) begin
        miscompares++;
        $display("FAIL fill_walk_%0d: seen=%b vpn=%h expected 1 %h", k, seen, xif.walk_vpn, v);
      end
      ack(p, 1'b0, 1'b0);
      cycles(2);
      vectors++;
      if (xif.paddr_out[31:0] !== {p, 12'h000} || xif.paddr_valid_out !== 2'b01) begin
        miscompares++;
        $display("FAIL fill_hit_%0d: paddr=%h pv=%b expected %h 01",
                 k, xif.paddr_out[31:0], xif.paddr_valid_out, {p, 12'h000});
      end
    end
    // Entries now: 0:#9 1:#10 2..7:#3..#8.
    xif.clc_in = {28'h0, 20'h00103, 8'h00};
    step();
    vectors++;
    if (xif.walk_req !== 1'b0 || xif.paddr_out[31:0] !== 32'h0A003000) begin
      miscompares++;
      $display("FAIL repl_keep3: walk_req=%b paddr=%h expected 0 0a003000",
               xif.walk_req, xif.paddr_out[31:0]);
    end
    xif.clc_in = {28'h0, 20'h00108, 8'h00};
    step();
    vectors++;
    if (xif.walk_req !== 1'b0 || xif.paddr_out[31:0] !== 32'h0A008000) begin
      miscompares++;
      $display("FAIL repl_keep8: walk_req=%b paddr=%h expected 0 0a008000",
               xif.walk_req, xif.paddr_out[31:0]);
    end
    xif.clc_in = {28'h0, 20'h00101, 8'h20};
    wait_req(seen);
    vectors++;
    if (!seen || xif.walk_vpn !== 20'h00101) begin
      miscompares++;
      $display("FAIL repl_evict1: seen=%b vpn=%h expected 1 00101", seen, xif.walk_vpn);
    end
    ack(20'h0F001, 1'b1, 1'b0);
    cycles(2);
    vectors++;
    if (xif.pcd_out !== 2'b01 || xif.paddr_out[31:0] !== 32'h0F001200) begin
      miscompares++;
      $display("FAIL repl_pcd: pcd=%b paddr=%h expected 01 0f001200",
               xif.pcd_out, xif.paddr_out[31:0]);
    end
    xif.clc_valid_in = 2'b00;
    step();
  endtask

  initial begin
    xif.clc_in       = '0;
    xif.clc_valid_in = '0;
    xif.stall_in     = 1'b0;
    xif.flush_in     = 1'b0;
    xif.tlb_inval_in = 1'b0;
    xif.walk_ack     = 1'b0;
    xif.walk_ppn     = '0;
    xif.walk_pcd     = 1'b0;
    xif.walk_fault   = 1'b0;
    test_reset();
    test_miss_hit();
    test_two_channels();
    test_fault();
    test_flush();
    test_stall();
    test_replacement();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
